// File: rtl/rc4_pkg.sv
// rtl/rc4_pkg.sv - shared types and widths for the RC4 key search controller
package rc4_pkg;

  localparam int KEY_W    = 24;
  localparam int S_ADDR_W = 8;
  localparam int S_DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_KSA   = 3'd2,
    ST_PRGA  = 3'd3,
    ST_FOUND = 3'd4,
    ST_FAIL  = 3'd5
  } rc4_state_e;

  // One S-memory request: address, write data and write enable.
  typedef struct packed {
    logic [S_ADDR_W-1:0] addr;
    logic [S_DATA_W-1:0] data;
    logic                wren;
  } s_req_t;

  // States in which one of the three tasks owns the S-memory.
  function automatic logic is_busy(rc4_state_e st);
    return (st == ST_INIT) || (st == ST_KSA) || (st == ST_PRGA);
  endfunction

endpackage

// File: rtl/rc4_key_sched_if.sv
// rtl/rc4_key_sched_if.sv - shared 256x8 S-memory port bundle
interface rc4_key_sched_if;

  logic [rc4_pkg::S_ADDR_W-1:0] s_addr;
  logic [rc4_pkg::S_DATA_W-1:0] s_data;
  logic                         s_wren;

  // The scheduler drives the memory; the memory consumes it.
  modport master (output s_addr, output s_data, output s_wren);
  modport slave  (input  s_addr, input  s_data, input  s_wren);

endinterface

// File: rtl/rc4_key_sched_s_mem_mux.sv
// rtl/rc4_key_sched_s_mem_mux.sv - routes the active task onto the shared S-memory port
module s_mem_mux
  import rc4_pkg::*;
(
  input  rc4_state_e state_i,
  input  s_req_t     t1_req_i,
  input  s_req_t     t2_req_i,
  input  s_req_t     t3_req_i,
  output s_req_t     s_req_o
);

  // Zero-latency select; outside the task states the port is fully quiet,
  // so stray task writes can never reach the memory.
  always_comb begin
    s_req_o = '0;
    case (state_i)
      ST_INIT: s_req_o = t1_req_i;
      ST_KSA:  s_req_o = t2_req_i;
      ST_PRGA: s_req_o = t3_req_i;
      default: s_req_o = '0;
    endcase
  end

endmodule

// File: rtl/rc4_key_sched.sv
// rtl/rc4_key_sched.sv - sequences init/KSA/decrypt tasks over a range of candidate keys
module rc4_key_sched
  import rc4_pkg::*;
#(
  parameter logic [KEY_W-1:0] KEY_START = 24'h000000,
  parameter logic [KEY_W-1:0] KEY_END   = 24'h3FFFFF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic [KEY_W-1:0]    key,
  output logic                t1_start,
  output logic                t2_start,
  output logic                t3_start,
  input  logic                t1_done,
  input  logic                t2_done,
  input  logic                t3_done,
  input  logic                t3_ok,
  input  logic [S_ADDR_W-1:0] t1_addr,
  input  logic [S_DATA_W-1:0] t1_data,
  input  logic                t1_wren,
  input  logic [S_ADDR_W-1:0] t2_addr,
  input  logic [S_DATA_W-1:0] t2_data,
  input  logic                t2_wren,
  input  logic [S_ADDR_W-1:0] t3_addr,
  input  logic [S_DATA_W-1:0] t3_data,
  input  logic                t3_wren,
  rc4_key_sched_if.master     s_mem,
  output logic                busy,
  output logic                done,
  output logic                found
);

  rc4_state_e      state_q;
  logic [KEY_W-1:0] key_q;
  logic [KEY_W-1:0] key_d;
  logic            t1_start_q, t2_start_q, t3_start_q;
  logic            busy_q, done_q, found_q;

  s_req_t t1_req, t2_req, t3_req, s_req;

  assign key_d = key_q + {{(KEY_W-1){1'b0}}, 1'b1};

  // Search FSM; start pulses and status flags are registered alongside the
  // state so each is asserted exactly on the cycle its state is entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      key_q      <= KEY_START;
      t1_start_q <= 1'b0;
      t2_start_q <= 1'b0;
      t3_start_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      found_q    <= 1'b0;
    end else begin
      t1_start_q <= 1'b0;
      t2_start_q <= 1'b0;
      t3_start_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_FOUND, ST_FAIL: begin
          if (start) begin
            state_q    <= ST_INIT;
            key_q      <= KEY_START;
            t1_start_q <= 1'b1;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            found_q    <= 1'b0;
          end
        end
        ST_INIT: begin
          if (t1_done) begin
            state_q    <= ST_KSA;
            t2_start_q <= 1'b1;
          end
        end
        ST_KSA: begin
          if (t2_done) begin
            state_q    <= ST_PRGA;
            t3_start_q <= 1'b1;
          end
        end
        ST_PRGA: begin
          if (t3_done) begin
            if (t3_ok) begin
              state_q <= ST_FOUND;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              found_q <= 1'b1;
            end else if (key_q == KEY_END) begin
              // Exhausted the range: stop on the last key rather than wrap.
              state_q <= ST_FAIL;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              found_q <= 1'b0;
            end else begin
              state_q    <= ST_INIT;
              key_q      <= key_d;
              t1_start_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          found_q <= 1'b0;
        end
      endcase
    end
  end

  assign t1_req = '{addr: t1_addr, data: t1_data, wren: t1_wren};
  assign t2_req = '{addr: t2_addr, data: t2_data, wren: t2_wren};
  assign t3_req = '{addr: t3_addr, data: t3_data, wren: t3_wren};

  s_mem_mux u_s_mem_mux (
    .state_i  (state_q),
    .t1_req_i (t1_req),
    .t2_req_i (t2_req),
    .t3_req_i (t3_req),
    .s_req_o  (s_req)
  );

  assign s_mem.s_addr = s_req.addr;
  assign s_mem.s_data = s_req.data;
  assign s_mem.s_wren = s_req.wren;

  assign key      = key_q;
  assign t1_start = t1_start_q;
  assign t2_start = t2_start_q;
  assign t3_start = t3_start_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign found    = found_q;

endmodule

// File: doc/rc4_key_sched.md
RC4_KEY_SCHED -- requirements
Module: rc4_key_sched

Interface
Parameters (name, default, meaning):
REQ-001 SHALL have KEY_START, 24'h000000, first key tried after start.
REQ-002 SHALL have KEY_END, 24'h3FFFFF, last key tried before declaring failure.

Ports (name, direction, width, meaning):
REQ-003 SHALL have clk input 1, single clock; all state changes on its rising edge.
REQ-004 SHALL have rst_n input 1, asynchronous active-low reset.
REQ-005 SHALL have start input 1, level sampled in IDLE/FOUND/FAIL to begin a key search.
REQ-006 SHALL have key output 24, current candidate key fed to all tasks.
REQ-007 SHALL have t1_start/t2_start/t3_start outputs 1 each, one-cycle start pulses to init, KSA and decrypt tasks.
REQ-008 SHALL have t1_done/t2_done/t3_done inputs 1 each, task completion pulses.
REQ-009 SHALL have t3_ok input 1, valid-plaintext flag qualified by t3_done.
REQ-010 SHALL have tN_addr input 8, tN_data input 8, tN_wren input 1 (N=1,2,3), per-task S-memory requests.
REQ-011 SHALL have s_addr output 8, s_data output 8, s_wren output 1, shared 256x8 S-memory port.
REQ-012 SHALL have busy, done, found outputs 1 each, search status.

Function
REQ-013 SHALL implement states IDLE, INIT, KSA, PRGA, FOUND, FAIL.
REQ-014 In IDLE, FOUND or FAIL, start=1 SHALL load key<=KEY_START and enter INIT on the next edge.
REQ-015 t1_start SHALL be high exactly the first cycle of each INIT visit; likewise t2_start for KSA, t3_start for PRGA.
REQ-016 t1_done=1 in INIT SHALL move to KSA; t2_done=1 in KSA SHALL move to PRGA.
REQ-017 t3_done=1 and t3_ok=1 in PRGA SHALL move to FOUND with key held unchanged.
REQ-018 t3_done=1 and t3_ok=0 with key!=KEY_END SHALL increment key by 1 and return to INIT.
REQ-019 t3_done=1 and t3_ok=0 with key==KEY_END SHALL move to FAIL; key SHALL NOT wrap.
REQ-020 Done pulses from a task other than the active one SHALL be ignored.
REQ-021 start SHALL be ignored while busy=1.
REQ-022 s_addr/s_data/s_wren SHALL combinationally (zero latency) follow t1_* in INIT, t2_* in KSA, t3_* in PRGA.
REQ-023 In IDLE/FOUND/FAIL, s_wren SHALL be 0 and s_addr, s_data SHALL be 0.
REQ-024 busy SHALL be 1 exactly in INIT, KSA, PRGA.
REQ-025 done SHALL be 1 in FOUND and FAIL; found SHALL be 1 only in FOUND; both SHALL hold until the next accepted start.
REQ-026 A task done arriving in the same cycle as its own start pulse SHALL be honoured (advance on the next edge).

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE, key=KEY_START, all tN_start=0, busy=done=found=0, s_wren=0.
REQ-028 Reset asserted mid-search SHALL abandon the search; no start pulse SHALL be issued until a new start after release.

Structure
REQ-029 A shared package rc4_pkg SHALL hold the state enum, KEY_W=24, S_ADDR_W=8, S_DATA_W=8.
REQ-030 The memory mux SHALL be a sub-module s_mem_mux (3 requesters, select from state, wren gating).

Verification
REQ-031 start=1 one cycle, tasks answer done 5 cycles after start, t3_ok=1 -> pulses t1,t2,t3 in order, FOUND, key=0, found=1, done=1.
REQ-032 t3_ok=0 for keys 0..2, 1 at key 3 -> four INIT/KSA/PRGA rounds, final key=24'h000003, found=1.
REQ-033 KEY_START=24'h3FFFFE, KEY_END=24'h3FFFFF, t3_ok always 0 -> two rounds, FAIL, key=24'h3FFFFF, found=0, done=1.
REQ-034 In KSA drive t2_addr=8'hA5, t2_data=8'h3C, t2_wren=1, t1_wren=1 -> s_addr=8'hA5, s_data=8'h3C, s_wren=1; t1 ignored; in IDLE s_wren=0.
REQ-035 Assert rst_n=0 mid-PRGA -> same instant IDLE, busy=0, s_wren=0; no tN_start until new start.
REQ-036 t3_done pulse while in INIT, start pulse while busy -> no state change, key unchanged.
